channel_arbiter: RTL and testbench

Round-robin arbiter that shares one blocking integer output channel among NUM_REQ blocking producer ports. Each transfer reads one word from the granted producer and forwards it, tagged with the producer index, to a single consumer. The block sits between generated section-based modules and uses the same sync/notify blocking-port handshake on every channel. Only one transfer is in flight at a time. The grant rotates so that no producer that holds its sync asserted can starve.

---
 rtl/channel_arbiter_pkg.sv | 13 +
 rtl/channel_arbiter_rr_picker.sv | 30 +++
 rtl/channel_arbiter.sv | 79 +++++++
 tb/tb_channel_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/channel_arbiter_pkg.sv
// Shared types for the round-robin channel arbiter: FSM sections and
// the largest supported producer count.
package channel_arbiter_types;

  typedef enum logic [1:0] {
    section_idle,
    section_read,
    section_write
  } Sections;

  localparam int MAX_REQ = 8;

endpackage

// File: rtl/channel_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit searching
// upward from last_grant+1, wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic               valid,
  output logic [ID_W-1:0]    grant
);

  logic [ID_W-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the search so no path
    // through the loop leaves a value unassigned, which would infer a latch.
    valid = 1'b0;
    grant = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(last_grant) + i) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        grant = cand;
      end
    end
  end

endmodule

// File: rtl/channel_arbiter.sv
// Round-robin arbiter forwarding one word at a time from NUM_REQ blocking
// producer ports to a single consumer, tagged with the producer index.
module channel_arbiter
  import channel_arbiter_types::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [31:0]  req_in [NUM_REQ],
  input  logic [NUM_REQ-1:0]  req_in_sync,
  output logic [NUM_REQ-1:0]  req_in_notify,
  output logic signed [31:0]  arb_out,
  output logic [ID_W-1:0]     arb_out_id,
  input  logic                arb_out_sync,
  output logic                arb_out_notify
);

  Sections         section;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] last_grant;
  logic            pick_valid;
  logic [ID_W-1:0] pick_grant;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req        (req_in_sync),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  // last_grant resets to the top index so producer 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      section        <= section_idle;
      grant          <= '0;
      last_grant     <= ID_W'(NUM_REQ - 1);
      req_in_notify  <= '0;
      arb_out        <= '0;
      arb_out_id     <= '0;
      arb_out_notify <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // the pre-edge values, so ordering inside this block does not matter.
      case (section)
        section_idle: begin
          if (pick_valid) begin
            grant         <= pick_grant;
            req_in_notify <= NUM_REQ'(1) << pick_grant;
            section       <= section_read;
          end
        end
        section_read: begin
          // A withdrawn producer keeps its grant; no re-arbitration here.
          if (req_in_sync[grant]) begin
            arb_out        <= req_in[grant];
            arb_out_id     <= grant;
            req_in_notify  <= '0;
            arb_out_notify <= 1'b1;
            section        <= section_write;
          end
        end
        section_write: begin
          if (arb_out_sync) begin
            arb_out_notify <= 1'b0;
            last_grant     <= grant;
            section        <= section_idle;
          end
        end
        default: section <= section_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_arbiter.sv
// Directed bench for channel_arbiter: a cycle table for the round-robin
// scenarios plus hand sequences for backpressure, withdrawal and reset.
module tb_channel_arbiter;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] req_in [4];
  logic [3:0]         req_in_sync;
  logic [3:0]         req_in_notify;
  logic signed [31:0] arb_out;
  logic [1:0]         arb_out_id;
  logic               arb_out_sync;
  logic               arb_out_notify;

  int checks = 0;
  int errors = 0;

  channel_arbiter #(.NUM_REQ(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_in         (req_in),
    .req_in_sync    (req_in_sync),
    .req_in_notify  (req_in_notify),
    .arb_out        (arb_out),
    .arb_out_id     (arb_out_id),
    .arb_out_sync   (arb_out_sync),
    .arb_out_notify (arb_out_notify)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sync;
    logic       out_sync;
    logic       rst_val;
    logic [3:0] exp_rn;
    logic       exp_on;
    int         exp_out;
    int         exp_id;
  } vec_t;

  vec_t vecs[$];
  int   data_word [4] = '{100, 101, 42, 103};

  function automatic void add(logic [3:0] s, logic os, logic r, logic [3:0] rn,
                              logic on, int o, int id);
    vec_t v;
    v.sync = s; v.out_sync = os; v.rst_val = r;
    v.exp_rn = rn; v.exp_on = on; v.exp_out = o; v.exp_id = id;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, int actual, int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(string tag, int rn, int on, int o, int id);
    check({tag, " req_in_notify"},  int'(req_in_notify), rn);
    check({tag, " arb_out_notify"}, int'(arb_out_notify), on);
    check({tag, " arb_out"},        int'(arb_out), o);
    check({tag, " arb_out_id"},     int'(arb_out_id), id);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_in_sync = '0;
    arb_out_sync = 1'b0;
    tick();
    check_outputs("reset", 0, 0, 0, 0);
    rst = 1'b1;
  endtask

  initial begin
    int prev_out, prev_id, id;

    for (int i = 0; i < 4; i++) req_in[i] = data_word[i];
    rst = 1'b0;
    req_in_sync = '0;
    arb_out_sync = 1'b1;
    #2;
    check_outputs("async reset", 0, 0, 0, 0);
    tick();
    rst = 1'b1;

    // Pair 1 and 3 right after reset: 1, 3, then 1 again.
    add(4'b1010, 1, 1, 4'b0010, 0,   0, 0);
    add(4'b1010, 1, 1, 4'b0000, 1, 101, 1);
    add(4'b1010, 1, 1, 4'b0000, 0, 101, 1);
    add(4'b1010, 1, 1, 4'b1000, 0, 101, 1);
    add(4'b1010, 1, 1, 4'b0000, 1, 103, 3);
    add(4'b1010, 1, 1, 4'b0000, 0, 103, 3);
    add(4'b1010, 1, 1, 4'b0010, 0, 103, 3);
    add(4'b1010, 1, 1, 4'b0000, 1, 101, 1);
    add(4'b0000, 1, 1, 4'b0000, 0, 101, 1);
    add(4'b0000, 1, 1, 4'b0000, 0, 101, 1);
    // Single producer 2 carrying 42.
    add(4'b0100, 1, 1, 4'b0100, 0, 101, 1);
    add(4'b0100, 1, 1, 4'b0000, 1,  42, 2);
    add(4'b0000, 1, 1, 4'b0000, 0,  42, 2);
    // Reset, then all four requesting: ids 0,1,2,3,0,1 one word per 3 cycles.
    add(4'b0000, 1, 0, 4'b0000, 0,   0, 0);
    prev_out = 0;
    prev_id  = 0;
    for (int k = 0; k < 6; k++) begin
      id = k % 4;
      add(4'b1111, 1, 1, 4'(1 << id), 0, prev_out, prev_id);
      add(4'b1111, 1, 1, 4'b0000, 1, data_word[id], id);
      add(4'b1111, 1, 1, 4'b0000, 0, data_word[id], id);
      prev_out = data_word[id];
      prev_id  = id;
    end

    foreach (vecs[i]) begin
      req_in_sync  = vecs[i].sync;
      arb_out_sync = vecs[i].out_sync;
      rst          = vecs[i].rst_val;
      tick();
      check_outputs($sformatf("vec%0d", i), int'(vecs[i].exp_rn),
                    int'(vecs[i].exp_on), vecs[i].exp_out, vecs[i].exp_id);
    end
    rst = 1'b1;

    // Consumer backpressure for 5 cycles in section_write.
    do_reset();
    req_in_sync = 4'b0001;
    arb_out_sync = 1'b0;
    tick();
    check_outputs("bp grant", 1, 0, 0, 0);
    tick();
    req_in_sync = 4'b0000;
    check_outputs("bp read", 0, 1, 100, 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check_outputs($sformatf("bp hold%0d", c), 0, 1, 100, 0);
    end
    arb_out_sync = 1'b1;
    tick();
    check_outputs("bp release", 0, 0, 100, 0);

    // Producer 0 withdraws for 3 cycles while producer 1 requests.
    do_reset();
    arb_out_sync = 1'b1;
    req_in_sync = 4'b0001;
    tick();
    check_outputs("wd grant", 1, 0, 0, 0);
    req_in_sync = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_outputs($sformatf("wd wait%0d", c), 1, 0, 0, 0);
    end
    req_in_sync = 4'b0011;
    tick();
    check_outputs("wd taken", 0, 1, 100, 0);

    // Reset asserted in section_write clears outputs without a clock edge.
    do_reset();
    arb_out_sync = 1'b0;
    req_in_sync = 4'b0001;
    tick();
    tick();
    check_outputs("mid write", 0, 1, 100, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs("mid reset", 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    req_in_sync = 4'b1111;
    arb_out_sync = 1'b1;
    tick();
    check_outputs("post reset", 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
